// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives start/a/b.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag (bus.ovf).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             brw_nx;
  logic             bit_d;
  logic             brw_q;
  logic             load;
  logic             last;

  assign bit_d  = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_nx = (~a_sh[0] & b_sh[0])
                | (~(a_sh[0] ^ b_sh[0]) & brw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // start is honoured only outside RUN, so a busy pulse is dropped
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      brw_q <= 1'b0;
    end else if (load) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      d_sh  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      brw_q <= 1'b0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {bit_d, d_sh[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      brw  <= brw_nx;
      if (last) brw_q <= brw_nx;
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = d_sh;
  assign bus.borrow_out = brw_q;

`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits are kept because the shift registers lose them
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=4 vectors and corner sequences,
// WIDTH=8 random sweep against a plain-arithmetic model.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   sel;

  serial_subtractor_if #(.WIDTH(4)) i4 ();
  serial_subtractor_if #(.WIDTH(8)) i8 ();

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk),
    .rst(rst),
    .bus(i4.slave)
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk),
    .rst(rst),
    .bus(i8.slave)
  );

  logic       s_busy;
  logic       s_done;
  logic [7:0] s_diff;
  logic       s_br;
  logic       s_ovf;

  always_comb begin
    s_busy = sel ? i8.busy : i4.busy;
    s_done = sel ? i8.done : i4.done;
    s_diff = sel ? i8.diff : {4'b0, i4.diff};
    s_br   = sel ? i8.borrow_out : i4.borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    s_ovf  = sel ? i8.ovf : i4.ovf;
`else
    s_ovf  = 1'b0;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // one operation: start at an edge, then count edges until done
  task automatic op(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                    output logic [7:0] d, output logic br, output logic ov,
                    output int lat, output int nb);
    sel = wide;
    @(posedge clk); #1;
    if (wide) begin
      i8.start = 1'b1; i8.a = av; i8.b = bv;
    end else begin
      i4.start = 1'b1; i4.a = av[3:0]; i4.b = bv[3:0];
    end
    @(posedge clk); #1;
    i4.start = 1'b0;
    i8.start = 1'b0;
    lat = 0;
    nb  = 0;
    while (!s_done && lat < 40) begin
      if (s_busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    d  = s_diff;
    br = s_br;
    ov = s_ovf;
  endtask

  logic [7:0] d;
  logic       br;
  logic       ov;
  int         lat;
  int         nb;
  int         cnt;

  initial begin
    total = 0;
    bad   = 0;
    sel   = 1'b0;
    rst   = 1'b1;
    i4.start = 1'b0; i4.a = '0; i4.b = '0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0;

    tv[0] = '{4'd7,  4'd3,  4'd4,  1'b0, 1'b0};
    tv[1] = '{4'd3,  4'd7,  4'd12, 1'b1, 1'b0};
    tv[2] = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
    tv[3] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
    tv[4] = '{4'd15, 4'd1,  4'd14, 1'b0, 1'b0};
    tv[5] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
    tv[6] = '{4'd5,  4'd3,  4'd2,  1'b0, 1'b0};
    tv[7] = '{4'd7,  4'd15, 4'd8,  1'b1, 1'b1};

    #12;
    chk("rst_busy", i4.busy, 0);
    chk("rst_done", i4.done, 0);
    chk("rst_diff", i4.diff, 0);
    chk("rst_borrow", i4.borrow_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      op(1'b0, {4'b0, tv[i].a}, {4'b0, tv[i].b}, d, br, ov, lat, nb);
      chk($sformatf("v%0d_diff", i), d, tv[i].d);
      chk($sformatf("v%0d_borrow", i), br, tv[i].br);
      chk($sformatf("v%0d_lat", i), lat, 4);
      chk($sformatf("v%0d_busy_cycles", i), nb, 4);
      chk($sformatf("v%0d_busy_in_done", i), s_busy, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), ov, tv[i].ov);
`endif
    end

    // result held while start stays low
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (s_done && !s_busy) cnt++;
    end
    chk("hold_done", cnt, 12);
    chk("hold_diff", s_diff, 8);
    chk("hold_borrow", s_br, 1);

    // back-to-back: start while busy is ignored
    sel = 1'b0;
    @(posedge clk); #1;
    i4.start = 1'b1; i4.a = 4'd9; i4.b = 4'd2;
    @(posedge clk); #1;
    i4.start = 1'b0;
    @(posedge clk); #1;
    i4.start = 1'b1; i4.a = 4'd1; i4.b = 4'd1;
    @(posedge clk); #1;
    i4.start = 1'b0;
    lat = 2;
    while (!s_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", lat, 4);
    chk("b2b_diff", s_diff, 7);
    chk("b2b_borrow", s_br, 0);
    // restart on the first DONE cycle
    i4.start = 1'b1; i4.a = 4'd5; i4.b = 4'd5;
    @(posedge clk); #1;
    i4.start = 1'b0;
    chk("restart_done_low", s_done, 0);
    chk("restart_busy", s_busy, 1);
    lat = 0;
    while (!s_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("restart_lat", lat, 4);
    chk("restart_diff", s_diff, 0);
    chk("restart_borrow", s_br, 0);

    // asynchronous reset in the second RUN cycle
    @(posedge clk); #1;
    i4.start = 1'b1; i4.a = 4'd15; i4.b = 4'd1;
    @(posedge clk); #1;
    i4.start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", s_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", s_busy, 0);
    chk("arst_done", s_done, 0);
    chk("arst_diff", s_diff, 0);
    chk("arst_borrow", s_br, 0);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (s_done || s_busy) cnt++;
    end
    chk("post_rst_idle", cnt, 0);

    // WIDTH=8 random sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] av;
      logic [7:0] bv;
      int         sd;
      av = 8'($urandom);
      bv = 8'($urandom);
      op(1'b1, av, bv, d, br, ov, lat, nb);
      chk($sformatf("r%0d_diff a=%0d b=%0d", i, av, bv), d, (int'(av) - int'(bv)) & 255);
      chk($sformatf("r%0d_borrow", i), br, int'(av < bv));
      chk($sformatf("r%0d_lat", i), lat, 8);
      sd = int'($signed(av)) - int'($signed(bv));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("r%0d_ovf", i), ov, int'(sd < -128 || sd > 127));
`else
      if (sd > 1000) $display("unexpected signed result %0d", sd);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
